svpwm_dwell_sequencer: RTL and testbench

SVPWM_DWELL_SEQUENCER -- requirements
Module: svpwm_dwell_sequencer

---
 rtl/svpwm_dwell_sequencer.sv | 162 ++++++++++++++++
 tb/tb_svpwm_dwell_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/svpwm_dwell_sequencer.sv
// SVPWM dwell-time sequencer: on each falling PWM strobe, waits SETTLE cycles, captures the
// sector inputs, reads two sine values from a shared LUT and computes the t1/t2/t0 dwell times.
module svpwm_dwell_sequencer #(
    parameter int unsigned PERIOD = 2000,
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        synchr_clk,
    input  logic [15:0] amplitude,
    input  logic [9:0]  sin_t1,
    input  logic [9:0]  sin_t2,
    input  logic [3:0]  number_sector,
    output logic        lut_req,
    output logic [9:0]  lut_addr,
    input  logic        lut_gnt,
    input  logic [15:0] lut_data,
    output logic [15:0] t1,
    output logic [15:0] t2,
    output logic [15:0] t0,
    output logic [3:0]  sector_out,
    output logic        valid,
    output logic        ovm,
    output logic        sector_fault,
    output logic        overrun
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [16:0] PERIOD_W = 17'(PERIOD);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_RD_T1, ST_WAIT_T1,
        ST_RD_T2, ST_WAIT_T2, ST_CALC, ST_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1, sync2, hist;
    logic          fall;
    logic [15:0]   amp_q, s1_q, s2_q;
    logic [9:0]    addr2_q;
    logic [3:0]    sec_q;

    logic [31:0]   sh1, sh2;
    logic [15:0]   t1_c, t2_c, t0_c;
    logic [16:0]   sum_c;
    logic          ovm_c;

    assign fall = hist & ~sync2;

    always_comb begin
        sh1   = ({16'b0, amp_q} * {16'b0, s1_q}) >> 13;
        sh2   = ({16'b0, amp_q} * {16'b0, s2_q}) >> 13;
        t1_c  = (sh1[31:16] != '0) ? '1 : sh1[15:0];
        t2_c  = (sh2[31:16] != '0) ? '1 : sh2[15:0];
        sum_c = {1'b0, t1_c} + {1'b0, t2_c};
        t0_c  = '0;
        ovm_c = 1'b1;
        if (sum_c <= PERIOD_W) begin
            // sum fits below PERIOD, so the 16-bit difference is exact
            t0_c  = PERIOD_W[15:0] - sum_c[15:0];
            ovm_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            hist         <= 1'b0;
            amp_q        <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            addr2_q      <= '0;
            sec_q        <= '0;
            lut_req      <= 1'b0;
            lut_addr     <= '0;
            t1           <= '0;
            t2           <= '0;
            t0           <= '0;
            sector_out   <= '0;
            valid        <= 1'b0;
            ovm          <= 1'b0;
            sector_fault <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sync1 <= synchr_clk;
            sync2 <= sync1;
            hist  <= sync2;
            if (fall && state != ST_IDLE)
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CNT_LAST) state <= ST_CAPTURE;
                    else                 cnt   <= cnt + CW'(1);
                end
                ST_CAPTURE: begin
                    // lut_addr doubles as the latched sin_t1
                    amp_q   <= amplitude;
                    sec_q   <= number_sector;
                    addr2_q <= sin_t2;
                    if (number_sector >= 4'd1 && number_sector <= 4'd6) begin
                        lut_req  <= 1'b1;
                        lut_addr <= sin_t1;
                        state    <= ST_RD_T1;
                    end else begin
                        sector_fault <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_RD_T1: begin
                    if (lut_gnt) begin
                        lut_req <= 1'b0;
                        state   <= ST_WAIT_T1;
                    end
                end
                ST_WAIT_T1: begin
                    s1_q     <= lut_data;
                    lut_req  <= 1'b1;
                    lut_addr <= addr2_q;
                    state    <= ST_RD_T2;
                end
                ST_RD_T2: begin
                    if (lut_gnt) begin
                        lut_req <= 1'b0;
                        state   <= ST_WAIT_T2;
                    end
                end
                ST_WAIT_T2: begin
                    s2_q  <= lut_data;
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    t1         <= t1_c;
                    t2         <= t2_c;
                    t0         <= t0_c;
                    ovm        <= ovm_c;
                    sector_out <= sec_q;
                    valid      <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    valid        <= 1'b0;
                    sector_fault <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_svpwm_dwell_sequencer.sv
// Directed and randomized checks of svpwm_dwell_sequencer against an arithmetic dwell-time model
// with a responding LUT that can stall its grant.
module tb_svpwm_dwell_sequencer;

    localparam int unsigned PER   = 2000;
    localparam int unsigned SET   = 4;
    localparam int          NLOOP = SET + 24;

    logic        clk = 1'b0;
    logic        reset, synchr_clk, lut_req, lut_gnt;
    logic        valid, ovm, sector_fault, overrun;
    logic [15:0] amplitude, t1, t2, t0;
    logic [15:0] lut_data = '0;
    logic [9:0]  sin_t1, sin_t2, lut_addr;
    logic [3:0]  number_sector, sector_out;
    logic [15:0] lut_mem [1024];

    int errors = 0;
    int checks = 0;
    int unsigned e_t1 = 0, e_t2 = 0, e_t0 = 0, e_sec = 0;
    bit e_ovm = 0, e_ovr = 0;

    svpwm_dwell_sequencer #(.PERIOD(PER), .SETTLE(SET)) dut (
        .clk(clk), .reset(reset), .synchr_clk(synchr_clk),
        .amplitude(amplitude), .sin_t1(sin_t1), .sin_t2(sin_t2),
        .number_sector(number_sector), .lut_req(lut_req), .lut_addr(lut_addr),
        .lut_gnt(lut_gnt), .lut_data(lut_data), .t1(t1), .t2(t2), .t0(t0),
        .sector_out(sector_out), .valid(valid), .ovm(ovm),
        .sector_fault(sector_fault), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // LUT answers one cycle after a granted request
    always @(posedge clk)
        if (lut_req && lut_gnt) lut_data <= lut_mem[lut_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int unsigned amp, input int unsigned s1, input int unsigned s2,
                                  output int unsigned r1, output int unsigned r2,
                                  output int unsigned r0, output bit ro);
        longint unsigned p1, p2, sum;
        p1  = (longint'(amp) * s1) / 8192;
        p2  = (longint'(amp) * s2) / 8192;
        r1  = (p1 > 65535) ? 65535 : int'(p1);
        r2  = (p2 > 65535) ? 65535 : int'(p2);
        sum = r1 + r2;
        if (sum <= PER) begin r0 = PER - int'(sum); ro = 0; end
        else            begin r0 = 0;               ro = 1; end
    endfunction

    task automatic fill(input int unsigned lo, input int unsigned hi);
        for (int i = 0; i < 1024; i++) lut_mem[i] = 16'($urandom_range(hi, lo));
    endtask

    task automatic run(input int unsigned amp, input int unsigned sec,
                       input int unsigned a1, input int unsigned a2,
                       input int stall, input int drop2, input int rst_at);
        int first_v = -1, first_f = -1, nv = 0, nf = 0, nreq = 0;
        int stall_left = stall;
        bit addr_bad = 0, prev_req = 0, prev_gnt = 1;
        logic [9:0] prev_addr = '0;
        int unsigned granted[$];
        int unsigned x1, x2, x0;
        bit xo;
        amplitude = 16'(amp); number_sector = 4'(sec);
        sin_t1 = 10'(a1); sin_t2 = 10'(a2);
        @(negedge clk);
        synchr_clk = 1'b0;
        for (int k = 1; k <= NLOOP; k++) begin
            @(negedge clk);
            if (k == 2) synchr_clk = 1'b1;
            if (drop2 > 0 && k == drop2) synchr_clk = 1'b0;
            if (drop2 > 0 && k == drop2 + 2) synchr_clk = 1'b1;
            if (valid) begin if (first_v < 0) first_v = k; nv++; end
            if (sector_fault) begin if (first_f < 0) first_f = k; nf++; end
            if (lut_req) begin
                nreq++;
                if (prev_req && !prev_gnt && lut_addr !== prev_addr) addr_bad = 1;
            end
            if (lut_req && stall_left > 0) begin lut_gnt = 1'b0; stall_left--; end
            else lut_gnt = 1'b1;
            if (lut_req && lut_gnt) granted.push_back(32'(lut_addr));
            prev_req = lut_req; prev_gnt = lut_gnt; prev_addr = lut_addr;
            if (rst_at > 0 && k == rst_at) reset = 1'b1;
            if (rst_at > 0 && k == rst_at + 1) begin
                reset = 1'b0;
                chk("rst_lut_req", 32'(lut_req), 0);
                chk("rst_t1", 32'(t1), 0);
                chk("rst_t2", 32'(t2), 0);
                chk("rst_t0", 32'(t0), 0);
                chk("rst_sector_out", 32'(sector_out), 0);
                chk("rst_ovm", 32'(ovm), 0);
                chk("rst_overrun", 32'(overrun), 0);
            end
        end
        lut_gnt = 1'b1;
        if (rst_at > 0) begin
            e_t1 = 0; e_t2 = 0; e_t0 = 0; e_sec = 0; e_ovm = 0; e_ovr = 0;
            chk("rst_no_valid", 32'(nv), 0);
            chk("rst_hold_t1", 32'(t1), 0);
        end else if (sec >= 1 && sec <= 6) begin
            model(amp, lut_mem[a1], lut_mem[a2], x1, x2, x0, xo);
            e_t1 = x1; e_t2 = x2; e_t0 = x0; e_ovm = xo; e_sec = sec;
            chk("latency", 32'(first_v), 32'(SET + 9 + stall));
            chk("valid_pulses", 32'(nv), 1);
            chk("fault_pulses", 32'(nf), 0);
            chk("t1", 32'(t1), e_t1);
            chk("t2", 32'(t2), e_t2);
            chk("t0", 32'(t0), e_t0);
            chk("ovm", 32'(ovm), 32'(e_ovm));
            chk("sector_out", 32'(sector_out), e_sec);
            chk("lut_reads", 32'(granted.size()), 2);
            if (granted.size() >= 2) begin
                chk("lut_addr1", granted[0], a1);
                chk("lut_addr2", granted[1], a2);
            end
            chk("addr_stable", 32'(addr_bad), 0);
        end else begin
            chk("fault_latency", 32'(first_f), 32'(SET + 4));
            chk("fault_pulses", 32'(nf), 1);
            chk("fault_no_valid", 32'(nv), 0);
            chk("fault_no_req", 32'(nreq), 0);
            chk("fault_hold_t1", 32'(t1), e_t1);
            chk("fault_hold_t2", 32'(t2), e_t2);
            chk("fault_hold_t0", 32'(t0), e_t0);
            chk("fault_hold_sec", 32'(sector_out), e_sec);
        end
        if (drop2 > 0) e_ovr = 1;
        chk("overrun", 32'(overrun), 32'(e_ovr));
    endtask

    initial begin
        reset = 1'b1; synchr_clk = 1'b1; lut_gnt = 1'b1;
        amplitude = '0; sin_t1 = '0; sin_t2 = '0; number_sector = '0;
        fill(0, 0);
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_lut_req", 32'(lut_req), 0);
        chk("reset_outputs", {t1, t2} | 32'({t0, sector_out, ovm, sector_fault, overrun}), 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        fill(1000, 1000);
        run(8000, 2, 100, 200, 0, 0, 0);          // nominal 976/976/48
        run(1234, 0, 5, 6, 0, 0, 0);              // invalid sectors hold results
        run(4321, 7, 9, 10, 0, 0, 0);
        fill(2000, 2000);
        run(8000, 3, 11, 12, 0, 0, 0);            // overmodulation
        fill(65535, 65535);
        run(65535, 1, 13, 14, 0, 0, 0);           // saturation
        fill(1000, 1000);
        run(8192, 4, 15, 16, 0, 0, 0);            // sum exactly PERIOD
        fill(1001, 1001);
        run(8192, 5, 17, 18, 0, 0, 0);            // sum just above PERIOD
        fill(0, 1100);
        run(8000, 6, 300, 700, 3, 0, 0);          // grant stall in first read
        for (int i = 0; i < 6; i++) begin
            fill(0, 1100);
            run($urandom_range(8000, 0), $urandom_range(6, 1), $urandom_range(960, 0),
                $urandom_range(960, 0), int'($urandom_range(3, 0)), 0, 0);
        end
        fill(0, 65535);
        run($urandom_range(65535, 0), 15, 1, 2, 0, 0, 0);
        fill(1000, 1000);
        run(8000, 2, 20, 21, 0, SET + 3, 0);      // second fall during WAIT_T1
        run(8000, 3, 22, 23, 0, 0, SET + 6);      // reset in RD_T2
        fill(0, 1100);
        run(7000, 1, 400, 500, 0, 0, 0);          // recovery after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
